// File: rtl/cln_key_loader.sv
// Serial key loader for the cln locking network.
// Bits arrive one per handshake and are collected in a shadow register.
// The complete key is then copied to K0/K1/K2 in a single edge, so the
// network never sees a partially loaded key.
module cln_key_loader #(
    parameter  int unsigned N      = 16,
    parameter  int unsigned STAGES = 6,
    localparam int unsigned KW     = N * STAGES / 2
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    input  logic          CLEAR,
    input  logic          KEY_IN,
    input  logic          KEY_VALID,
    output logic          KEY_READY,
    output logic [KW-1:0] K0,
    output logic [KW-1:0] K1,
    output logic [KW-1:0] K2,
    output logic          KEY_LOCKED,
    output logic          BUSY
);

    localparam int unsigned NK = 3 * KW;
    localparam int unsigned CW = $clog2(NK + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e        state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [NK-1:0] shadow_q, shadow_d;
    logic [KW-1:0] k0_q,     k0_d;
    logic [KW-1:0] k1_q,     k1_d;
    logic [KW-1:0] k2_q,     k2_d;
    logic          ready_q,  ready_d;
    logic          busy_q,   busy_d;
    logic          locked_q, locked_d;

    // State, shadow, active key and status flags
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            shadow_q <= '0;
            k0_q     <= '0;
            k1_q     <= '0;
            k2_q     <= '0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shadow_q <= shadow_d;
            k0_q     <= k0_d;
            k1_q     <= k1_d;
            k2_q     <= k2_d;
            ready_q  <= ready_d;
            busy_q   <= busy_d;
            locked_q <= locked_d;
        end
    end

    // Next-state: CLEAR beats START beats a bit transfer
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shadow_d = shadow_q;
        k0_d     = k0_q;
        k1_d     = k1_q;
        k2_d     = k2_q;

        if (CLEAR) begin
            state_d  = ST_IDLE;
            cnt_d    = '0;
            shadow_d = '0;
            k0_d     = '0;
            k1_d     = '0;
            k2_d     = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                ST_SHIFT: begin
                    if (START) begin
                        // restart: the new load overwrites earlier bits
                        cnt_d = '0;
                    end else if (KEY_VALID) begin
                        shadow_d[cnt_q] = KEY_IN;
                        cnt_d           = cnt_q + CW'(1);
                        if (cnt_q == CW'(NK - 1)) begin
                            state_d = ST_COMMIT;
                        end
                    end
                end
                ST_COMMIT: begin
                    // START is ignored here; the commit always completes
                    k0_d    = shadow_q[KW-1:0];
                    k1_d    = shadow_q[2*KW-1:KW];
                    k2_d    = shadow_q[NK-1:2*KW];
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (START) begin
                        state_d = ST_SHIFT;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Status flags are registered copies of the decoded next state
    always_comb begin
        ready_d  = 1'b0;
        busy_d   = 1'b0;
        locked_d = 1'b0;
        unique case (state_d)
            ST_SHIFT: begin
                ready_d = 1'b1;
                busy_d  = 1'b1;
            end
            ST_COMMIT: begin
                busy_d = 1'b1;
            end
            ST_DONE: begin
                locked_d = 1'b1;
            end
            default: begin
                ready_d  = 1'b0;
            end
        endcase
    end

    assign KEY_READY  = ready_q;
    assign BUSY       = busy_q;
    assign KEY_LOCKED = locked_q;
    assign K0         = k0_q;
    assign K1         = k1_q;
    assign K2         = k2_q;

endmodule

// File: tb/tb_cln_key_loader.sv
// Bench for cln_key_loader: table of full loads, hand-built corner
// sequences and random traffic, all checked against a queue-based model.
module tb_cln_key_loader;

    localparam int unsigned N      = 16;
    localparam int unsigned STAGES = 6;
    localparam int unsigned KW     = 48;
    localparam int unsigned NK     = 144;

    localparam logic [47:0] ONES = 48'hFFFF_FFFF_FFFF;
    localparam logic [47:0] ALT5 = 48'h5555_5555_5555;
    localparam logic [47:0] ALTA = 48'hAAAA_AAAA_AAAA;

    logic          CLK   = 1'b0;
    logic          RST_N = 1'b1;
    logic          START = 1'b0;
    logic          CLEAR = 1'b0;
    logic          KEY_IN = 1'b0;
    logic          KEY_VALID = 1'b0;
    logic          KEY_READY;
    logic [KW-1:0] K0, K1, K2;
    logic          KEY_LOCKED;
    logic          BUSY;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: loading / commit-pending flags, bits accepted so far,
    // and the active key as a flat bit array (bit j of the load order).
    logic          m_load;
    logic          m_commit;
    logic          m_locked;
    logic [NK-1:0] m_key;
    logic          m_q[$];

    typedef struct {
        int          sel;
        int          thr;
        logic [47:0] k0;
        logic [47:0] k1;
        logic [47:0] k2;
        int          busy;
    } vec_t;

    vec_t tbl[4];

    cln_key_loader #(.N(N), .STAGES(STAGES)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .CLEAR      (CLEAR),
        .KEY_IN     (KEY_IN),
        .KEY_VALID  (KEY_VALID),
        .KEY_READY  (KEY_READY),
        .K0         (K0),
        .K1         (K1),
        .K2         (K2),
        .KEY_LOCKED (KEY_LOCKED),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [159:0] dut_vec();
        return {13'b0, K0, K1, K2, KEY_READY, KEY_LOCKED, BUSY};
    endfunction

    function automatic logic [159:0] mdl_vec();
        return {13'b0, m_key[47:0], m_key[95:48], m_key[143:96],
                m_load, m_locked, m_load | m_commit};
    endfunction

    task automatic model_reset();
        m_load   = 1'b0;
        m_commit = 1'b0;
        m_locked = 1'b0;
        m_key    = '0;
        m_q.delete();
    endtask

    // Test pattern: 48 ones, 48 zeros, then 1,0,1,0...; sel=1 inverts it
    function automatic logic pat(input int sel, input int j);
        logic b;
        if (j < 48)      b = 1'b1;
        else if (j < 96) b = 1'b0;
        else             b = ((j - 96) % 2 == 0);
        return (sel == 1) ? ~b : b;
    endfunction

    // One clock: drive, advance model at the edge, compare just after it
    task automatic step(input logic st, input logic cl, input logic kin, input logic kv);
        @(negedge CLK);
        START = st; CLEAR = cl; KEY_IN = kin; KEY_VALID = kv;
        @(posedge CLK);
        if (cl) begin
            model_reset();
        end else if (m_commit) begin
            for (int j = 0; j < NK; j++) m_key[j] = m_q[j];
            m_q.delete();
            m_commit = 1'b0;
            m_locked = 1'b1;
        end else if (st) begin
            m_load   = 1'b1;
            m_locked = 1'b0;
            m_q.delete();
        end else if (m_load && kv) begin
            m_q.push_back(kin);
            if (m_q.size() == NK) begin
                m_load   = 1'b0;
                m_commit = 1'b1;
            end
        end
        #1;
        check("cycle", dut_vec(), mdl_vec());
    endtask

    // Full load from START until KEY_LOCKED; reports busy cycles and lock latency
    task automatic load(input int sel, input int thr, output int busy_n, output int lat);
        int   last;
        int   lk;
        logic v;
        logic acc;
        last   = -1;
        lk     = -1;
        busy_n = 0;
        step(1'b1, 1'b0, 1'($urandom), 1'b1);
        if (BUSY) busy_n++;
        for (int k = 1; k < 1000 && lk < 0; k++) begin
            v   = (thr == 0) || (k % 2 == 1);
            acc = v && m_load && (m_q.size() == NK - 1);
            step(1'b0, 1'b0, pat(sel, m_q.size()), v);
            if (acc) last = k;
            if (BUSY) busy_n++;
            if (KEY_LOCKED) lk = k;
        end
        if (lk < 0) check("load_lock_timeout", 160'(KEY_LOCKED), 160'(1));
        lat = lk - last;
    endtask

    initial begin
        int b;
        int l;

        tbl[0] = '{0, 0, ONES, 48'h0, ALT5, 145};
        tbl[1] = '{0, 1, ONES, 48'h0, ALT5, 288};
        tbl[2] = '{1, 0, 48'h0, ONES, ALTA, 145};
        tbl[3] = '{1, 1, 48'h0, ONES, ALTA, 288};

        model_reset();

        // Reset held with random inputs
        #1 RST_N = 1'b0;
        repeat (5) begin
            @(negedge CLK);
            START = 1'($urandom); CLEAR = 1'($urandom);
            KEY_IN = 1'($urandom); KEY_VALID = 1'($urandom);
            @(posedge CLK);
            #1 check("reset_hold", dut_vec(), 160'(0));
        end
        @(negedge CLK);
        START = 1'b0; CLEAR = 1'b0; KEY_VALID = 1'b0;
        RST_N = 1'b1;
        repeat (5) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));

        // Table of full loads
        for (int i = 0; i < 4; i++) begin
            load(tbl[i].sel, tbl[i].thr, b, l);
            check("tbl_k0", 160'(K0), 160'(tbl[i].k0));
            check("tbl_k1", 160'(K1), 160'(tbl[i].k1));
            check("tbl_k2", 160'(K2), 160'(tbl[i].k2));
            check("tbl_busy_cycles", 160'(b), 160'(tbl[i].busy));
            check("tbl_lock_latency", 160'(l), 160'(1));
        end

        // Restart: key A committed, partial load, restart into key B
        load(0, 0, b, l);
        step(1'b1, 1'b0, 1'($urandom), 1'b1);
        repeat (50) step(1'b0, 1'b0, 1'($urandom), 1'b1);
        check("restart_hold_key", 160'({K0, K1, K2}), 160'({ONES, 48'h0, ALT5}));
        check("restart_unlocked", 160'(KEY_LOCKED), 160'(0));
        load(1, 0, b, l);
        check("restart_key_b", 160'({K0, K1, K2}), 160'({48'h0, ONES, ALTA}));
        check("restart_lock_latency", 160'(l), 160'(1));

        // START during COMMIT is ignored
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < NK; j++) step(1'b0, 1'b0, pat(0, j), 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("start_in_commit_locked", 160'({KEY_LOCKED, BUSY, KEY_READY}), 160'(3'b100));
        check("start_in_commit_key", 160'({K0, K1, K2}), 160'({ONES, 48'h0, ALT5}));

        // CLEAR in SHIFT at bit 100 with a valid bit present
        load(1, 0, b, l);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 100; j++) step(1'b0, 1'b0, pat(0, j), 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        check("clear_shift_keys", 160'({K0, K1, K2}), 160'(0));
        check("clear_shift_flags", 160'({KEY_LOCKED, BUSY, KEY_READY}), 160'(0));
        repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);

        // CLEAR in DONE
        load(0, 0, b, l);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        check("clear_done_keys", 160'({K0, K1, K2}), 160'(0));
        check("clear_done_locked", 160'(KEY_LOCKED), 160'(0));

        // Asynchronous reset mid-cycle at bit 70, then a clean reload
        load(1, 0, b, l);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 70; j++) step(1'b0, 1'b0, pat(0, j), 1'b1);
        #2 RST_N = 1'b0;
        #1 check("async_reset_midcycle", dut_vec(), 160'(0));
        model_reset();
        @(negedge CLK);
        START = 1'b0; CLEAR = 1'b0; KEY_VALID = 1'b0;
        RST_N = 1'b1;
        load(0, 0, b, l);
        check("post_reset_key", 160'({K0, K1, K2}), 160'({ONES, 48'h0, ALT5}));
        check("post_reset_latency", 160'(l), 160'(1));

        // Random traffic against the model
        repeat (4000) begin
            step(1'($urandom % 300 == 0), 1'($urandom % 1500 == 0),
                 1'($urandom), 1'($urandom % 4 != 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
